// File: rtl/pong_pkg.sv
// Shared pong constants: coordinate width, sprite size and the round-ball bitmap.
package pong_pkg;

    localparam int COORD_W    = 10;
    localparam int SPRITE_DIM = 8;

    // Index r holds bitmap row r; bit 7 is the leftmost pixel.
    localparam logic [7:0][7:0] BALL_BITMAP = {
        8'b00111100,
        8'b01111110,
        8'b11111111,
        8'b11111111,
        8'b11111111,
        8'b11111111,
        8'b01111110,
        8'b00111100
    };

endpackage

// File: rtl/ball_bitmap.sv
// Combinational row lookup into the shared ball bitmap.
module ball_bitmap
    import pong_pkg::*;
(
    input  logic [2:0] addr,
    output logic [7:0] data
);

    assign data = BALL_BITMAP[addr];

endmodule

// File: rtl/ball_sprite_renderer.sv
// Two-beat pixel pipeline that decides whether the current pixel lies on the ball.
module ball_sprite_renderer #(
    parameter int COORD_W    = 10,
    parameter int SCALE_LOG2 = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_en,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               video_on,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    output logic               ball_on,
    output logic               video_on_d
);
    import pong_pkg::*;

    localparam int DIM = SPRITE_DIM << SCALE_LOG2;
    localparam logic [COORD_W:0] DIM_V = (COORD_W+1)'(DIM);

    logic [COORD_W-1:0] bx_q, by_q;
    logic [COORD_W:0]   dx, dy;
    logic               in_box;
    logic [2:0]         row_q, col_q;
    logic               in_box_q, vid_q;
    logic [7:0]         row_data;

    // Latched once per frame so motion updates never tear the sprite.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bx_q <= '0;
            by_q <= '0;
        end else if (frame_tick) begin
            bx_q <= ball_x;
            by_q <= ball_y;
        end
    end

    // Zero-extended subtraction: a negative result means left of / above the ball.
    assign dx = {1'b0, pix_x} - {1'b0, bx_q};
    assign dy = {1'b0, pix_y} - {1'b0, by_q};

    assign in_box = !dx[COORD_W] && (dx < DIM_V) &&
                    !dy[COORD_W] && (dy < DIM_V);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            vid_q    <= 1'b0;
        end else if (pix_en) begin
            in_box_q <= in_box;
            row_q    <= dy[SCALE_LOG2+2:SCALE_LOG2];
            col_q    <= dx[SCALE_LOG2+2:SCALE_LOG2];
            vid_q    <= video_on;
        end
    end

    ball_bitmap u_bitmap (
        .addr (row_q),
        .data (row_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ball_on    <= 1'b0;
            video_on_d <= 1'b0;
        end else if (pix_en) begin
            ball_on    <= vid_q & in_box_q & row_data[3'd7 - col_q];
            video_on_d <= vid_q;
        end
    end

endmodule

// File: doc/ball_sprite_renderer.md
# ball_sprite_renderer

Pixel-pipeline reader of the round-ball bitmap. For each pixel coordinate from the VGA sync generator, it decides whether that pixel belongs to the ball. It does this by comparing the pixel against a frame-latched ball position, forming the 3-bit bitmap row address and column index, and masking the square ball zone with the bitmap row data. It sits between the ball-motion logic and the pixel colour multiplexer, and produces `ball_on` aligned with a delayed `video_on`.

## Interface
Parameters:
- `COORD_W`, default 10: width of every pixel and position coordinate.
- `SCALE_LOG2`, default 0: each bitmap cell covers a 2^SCALE_LOG2 × 2^SCALE_LOG2 pixel block. The sprite is therefore (8 << SCALE_LOG2) pixels square. Legal values are 0..2.

Ports:
- `clk` in 1: system clock. There is one clock only.
- `reset_n` in 1: reset. It is asynchronous and active-low.
- `pix_en` in 1: pixel-rate enable pulse. The pipeline advances only in cycles where this is high.
- `pix_x` in COORD_W: current pixel column from the sync generator.
- `pix_y` in COORD_W: current pixel row from the sync generator.
- `video_on` in 1: the current pixel is in the visible area.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `ball_x` in COORD_W: ball top-left column, taken from the motion logic.
- `ball_y` in COORD_W: ball top-left row, taken from the motion logic.
- `ball_on` out 1: the pixel two `pix_en` beats earlier is a lit ball pixel.
- `video_on_d` out 1: `video_on` delayed by the same two beats.

## Operation
- Position latch:
  - `bx_q`/`by_q` load `ball_x`/`ball_y` in any cycle where `frame_tick`=1, regardless of `pix_en`.
  - Otherwise they hold.
  - Mid-frame changes to `ball_x`/`ball_y` have no effect until the next `frame_tick`, so there is no tearing.
- Stage 1, on `pix_en`:
  - dx = `pix_x` − `bx_q` and dy = `pix_y` − `by_q`, both computed at COORD_W+1 bits, two's complement.
  - `in_box_q` = (dx ≥ 0) and (dx < 8<<SCALE_LOG2) and (dy ≥ 0) and (dy < 8<<SCALE_LOG2).
  - `row_q` = dy[SCALE_LOG2+2:SCALE_LOG2] and `col_q` = dx[SCALE_LOG2+2:SCALE_LOG2].
  - `vid_q` = `video_on`.
- Stage 2, on `pix_en`:
  - `ball_on` = `vid_q` & `in_box_q` & bitmap(`row_q`)[7 − `col_q`]. Bit 7 is the leftmost pixel.
  - `video_on_d` = `vid_q`.
- Bitmap rows 0..7: 00111100, 01111110, 11111111, 11111111, 11111111, 11111111, 01111110, 00111100.
- Boundary conditions:
  - No horizontal or vertical wrap. A ball positioned near the right or bottom edge is clipped: for example, `bx_q`=1020 never lights `pix_x`=0..3.
  - Out-of-box pixels produce `ball_on`=0 whatever the row/column bits hold.
  - When `video_on`=0, `ball_on`=0.
- Simultaneous events: if `frame_tick` and `pix_en` are both high in one cycle, stage 1 uses the old `bx_q`/`by_q`. The new position is effective from the next cycle.
- Reset, including reset asserted mid-frame: `bx_q`, `by_q`, `row_q`, `col_q`, `in_box_q`, `vid_q`, `ball_on` and `video_on_d` all clear to 0 immediately. Drawing resumes correctly from the first `frame_tick` after release.

## Timing
- Latency is exactly 2 `pix_en` beats from `pix_x`/`pix_y`/`video_on` to `ball_on`/`video_on_d`.
- With `pix_en` tied high, latency is 2 clocks.
- When `pix_en`=0, all pipeline registers hold, so outputs are stable between enables.
- Position update latency: `bx_q`/`by_q` change 1 clock after `frame_tick`. The new position is first used on the next `pix_en`.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package `pong_pkg`: `COORD_W`, `SPRITE_DIM` (=8), and the 8-entry ball bitmap constant array. The bitmap is shared with any other consumer.
- One sub-module, `ball_bitmap`: a combinational 3-bit-address → 8-bit-data lookup from `pong_pkg`, instantiated in stage 2.
- The sync-generator delay matching for hsync/vsync is done by the consumer, using the same 2-beat offset.

## Test plan
All scenarios use SCALE_LOG2=0, `pix_en` tied high, and ball latched at (100,50), unless stated otherwise.
- Latched ball at (100,50). Drive pixel (103,50), video_on=1 → `ball_on`=1 exactly 2 clocks later. Drive (100,50) → 0 (corner). Drive (100,52) → 1. Drive (107,57) → 0 (corner).
- Drive (108,52) and (99,52) → `ball_on`=0 (outside the box). Drive (103,50) with video_on=0 → 0.
- Latch the ball at x=1020, y=50. Sweep `pix_x` 0..7 on row 52 → `ball_on` stays 0, confirming no wrap. Sweep `pix_x` 1020..1023 → all 1.
- Change `ball_x` to 200 mid-frame without `frame_tick` → drawing stays at x=100. Pulse `frame_tick` together with `pix_en` → the same-cycle pixel uses x=100, and from the next pixel onward x=200 is used.
- Toggle `pix_en` 1-of-4 → outputs update only on enable beats. Latency is 2 enables, not 2 clocks.
- Assert `reset_n`=0 mid-frame while `ball_on`=1 → `ball_on` and `video_on_d` drop to 0 asynchronously. After release, the ball is drawn at (0,0) until the next `frame_tick` latches the new position.
